// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam int ERR_PARITY    = 0;
  localparam int ERR_STOP      = 1;
  localparam int PS2_DATA_BITS = 8;

  function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// First-word-fall-through FIFO; head entry is visible whenever not empty, zero when empty.
module ps2_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (level_r == LW'(0));
  assign full      = (level_r == LW'(DEPTH));
  // A push into a full FIFO is only legal when a pop frees the slot in the same cycle.
  assign do_push_s = push && (!full || pop);
  assign do_pop_s  = pop && !empty;
  assign level     = level_r;
  assign pop_data  = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      level_r <= level_r + LW'(do_push_s) - LW'(do_pop_s);
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronise, deglitch the clock, deframe bytes with
// parity/stop checking and a frame timeout, and queue results in a FWFT FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            PS2_CLK_IN,
  input  logic                            PS2_DATA_IN,
  input  logic                            ENABLE,
  input  logic                            RD_EN,
  output logic [7:0]                      RD_DATA,
  output logic [1:0]                      RD_ERR,
  output logic                            EMPTY,
  output logic                            FULL,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] LEVEL,
  output logic                            OVERFLOW,
  input  logic                            CLR_OVERFLOW,
  output logic                            TIMEOUT_PULSE,
  output logic [1:0]                      STATE
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int EW = PS2_DATA_BITS + 2;

  logic [SYNC_STAGES-1:0]   clk_sync_r;
  logic [SYNC_STAGES-1:0]   data_sync_r;
  logic                     ps2_clk_s;
  logic                     data_s;
  logic                     filt_r;
  logic                     filt_prev_r;
  logic [FW-1:0]            filt_cnt_r;
  logic                     sample_s;

  ps2_state_e               state_r, state_n;
  logic [2:0]               bit_cnt_r, bit_cnt_n;
  logic [PS2_DATA_BITS-1:0] shift_r, shift_n;
  logic                     par_err_r, par_err_n;
  logic [TW-1:0]            timer_r, timer_n;
  logic                     timer_hit_s;
  logic                     abort_s;
  logic                     timeout_s;
  logic                     push_s;
  logic [EW-1:0]            entry_s;
  logic [EW-1:0]            head_s;
  logic                     overflow_r;
  logic                     timeout_pulse_r;

  assign ps2_clk_s = clk_sync_r[SYNC_STAGES-1];
  assign data_s    = data_sync_r[SYNC_STAGES-1];
  assign sample_s  = filt_prev_r & ~filt_r;

  // Input synchronisers, preset to the idle-high bus level.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      clk_sync_r  <= '1;
      data_sync_r <= '1;
    end else begin
      clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], PS2_CLK_IN};
      data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], PS2_DATA_IN};
    end
  end

  // Clock glitch filter: accept a new level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      filt_r      <= 1'b1;
      filt_prev_r <= 1'b1;
      filt_cnt_r  <= '0;
    end else begin
      filt_prev_r <= filt_r;
      if (ps2_clk_s != filt_r) begin
        if (filt_cnt_r == FW'(FILTER_LEN - 1)) begin
          filt_r     <= ps2_clk_s;
          filt_cnt_r <= '0;
        end else begin
          filt_cnt_r <= filt_cnt_r + FW'(1);
        end
      end else begin
        filt_cnt_r <= '0;
      end
    end
  end

  // Disable and timeout both abandon a frame in progress; disable suppresses the pulse.
  assign timer_hit_s = (timer_r == TW'(TIMEOUT_CYCLES - 1));
  assign abort_s     = (state_r != IDLE) && (!ENABLE || timer_hit_s);
  assign timeout_s   = (state_r != IDLE) && ENABLE && timer_hit_s;

  // Deframing next-state logic.
  always_comb begin
    state_n   = state_r;
    bit_cnt_n = bit_cnt_r;
    shift_n   = shift_r;
    par_err_n = par_err_r;
    timer_n   = timer_r;
    push_s    = 1'b0;
    if (abort_s) begin
      state_n = IDLE;
      timer_n = '0;
    end else begin
      if (sample_s) begin
        timer_n = '0;
      end else begin
        timer_n = timer_r + TW'(1);
      end
      case (state_r)
        IDLE: begin
          timer_n = '0;
          if (sample_s && ENABLE && !data_s) begin
            state_n   = DATA;
            bit_cnt_n = 3'd0;
          end else begin
            state_n = IDLE;
          end
        end
        DATA: begin
          if (sample_s) begin
            shift_n   = {data_s, shift_r[PS2_DATA_BITS-1:1]};
            bit_cnt_n = bit_cnt_r + 3'd1;
            state_n   = (bit_cnt_r == 3'd7) ? PARITY : DATA;
          end else begin
            state_n = DATA;
          end
        end
        PARITY: begin
          if (sample_s) begin
            par_err_n = (data_s != odd_parity(shift_r));
            state_n   = STOP;
          end else begin
            state_n = PARITY;
          end
        end
        STOP: begin
          if (sample_s) begin
            push_s  = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = STOP;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // Deframing state registers and the registered timeout pulse.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r         <= IDLE;
      bit_cnt_r       <= 3'd0;
      shift_r         <= '0;
      par_err_r       <= 1'b0;
      timer_r         <= '0;
      timeout_pulse_r <= 1'b0;
    end else begin
      state_r         <= state_n;
      bit_cnt_r       <= bit_cnt_n;
      shift_r         <= shift_n;
      par_err_r       <= par_err_n;
      timer_r         <= timer_n;
      timeout_pulse_r <= timeout_s;
    end
  end

  // Entry layout: {stop_err, parity_err, byte}, matching the RD_ERR bit assignment.
  assign entry_s = {~data_s, par_err_r, shift_r};

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      overflow_r <= 1'b0;
    end else if (push_s && FULL && !RD_EN) begin
      overflow_r <= 1'b1;
    end else if (CLR_OVERFLOW) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  ps2_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .reset     (RESET),
    .push      (push_s),
    .push_data (entry_s),
    .pop       (RD_EN),
    .pop_data  (head_s),
    .empty     (EMPTY),
    .full      (FULL),
    .level     (LEVEL)
  );

  assign RD_DATA       = head_s[PS2_DATA_BITS-1:0];
  assign RD_ERR        = {head_s[PS2_DATA_BITS+ERR_STOP], head_s[PS2_DATA_BITS+ERR_PARITY]};
  assign OVERFLOW      = overflow_r;
  assign TIMEOUT_PULSE = timeout_pulse_r;
  assign STATE         = state_r;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frames driven bit by bit, expected values hand-computed.
module tb_ps2_rx_fifo;

  localparam int H = 20;  // PS/2 half-period in CLK cycles

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       PS2_CLK_IN = 1'b1;
  logic       PS2_DATA_IN = 1'b1;
  logic       ENABLE = 1'b1;
  logic       RD_EN = 1'b0;
  logic       CLR_OVERFLOW = 1'b0;
  logic [7:0] RD_DATA;
  logic [1:0] RD_ERR;
  logic       EMPTY;
  logic       FULL;
  logic [3:0] LEVEL;
  logic       OVERFLOW;
  logic       TIMEOUT_PULSE;
  logic [1:0] STATE;

  int n_checks = 0;
  int n_errors = 0;

  ps2_rx_fifo dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .PS2_CLK_IN    (PS2_CLK_IN),
    .PS2_DATA_IN   (PS2_DATA_IN),
    .ENABLE        (ENABLE),
    .RD_EN         (RD_EN),
    .RD_DATA       (RD_DATA),
    .RD_ERR        (RD_ERR),
    .EMPTY         (EMPTY),
    .FULL          (FULL),
    .LEVEL         (LEVEL),
    .OVERFLOW      (OVERFLOW),
    .CLR_OVERFLOW  (CLR_OVERFLOW),
    .TIMEOUT_PULSE (TIMEOUT_PULSE),
    .STATE         (STATE)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Drive bits[0..nbits-1]; optional 2-cycle clock glitch in the high phase of glitch_bit,
  // optional pop aligned with the stop-bit push (6 = SYNC_STAGES + FILTER_LEN edges after fall).
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int glitch_bit,
                           input bit pop_at_stop);
    for (int i = 0; i < nbits; i++) begin
      PS2_DATA_IN = bits[i];
      for (int j = 0; j < H; j++) begin
        tick(1);
        if (i == glitch_bit && j == H/2)     PS2_CLK_IN = 1'b0;
        if (i == glitch_bit && j == H/2 + 2) PS2_CLK_IN = 1'b1;
      end
      PS2_CLK_IN = 1'b0;
      for (int j = 0; j < H; j++) begin
        tick(1);
        if (pop_at_stop && i == 10 && j == 5) RD_EN = 1'b1;
        if (pop_at_stop && i == 10 && j == 6) RD_EN = 1'b0;
      end
      PS2_CLK_IN = 1'b1;
    end
    PS2_DATA_IN = 1'b1;
    tick(2);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p, input logic s,
                            input int glitch_bit, input bit pop_at_stop);
    send_bits({s, p, b, 1'b0}, 11, glitch_bit, pop_at_stop);
  endtask

  task automatic read_entry(input string tag, input logic [7:0] exp_data, input logic [1:0] exp_err);
    check_val({tag, "_data"}, {24'd0, RD_DATA}, {24'd0, exp_data});
    check_val({tag, "_err"}, {30'd0, RD_ERR}, {30'd0, exp_err});
    RD_EN = 1'b1;
    tick(1);
    RD_EN = 1'b0;
  endtask

  initial begin
    int pulses;
    logic [7:0] b;

    tick(3);
    RESET = 1'b0;
    tick(1);
    check_val("rst_empty", {31'd0, EMPTY}, 32'd1);
    check_val("rst_full", {31'd0, FULL}, 32'd0);
    check_val("rst_level", {28'd0, LEVEL}, 32'd0);
    check_val("rst_ovf", {31'd0, OVERFLOW}, 32'd0);
    check_val("rst_state", {30'd0, STATE}, 32'd0);
    check_val("rst_data", {24'd0, RD_DATA}, 32'd0);

    // 1: 0xA5 (four ones, odd parity bit 1), good stop
    send_frame(8'hA5, 1'b1, 1'b1, -1, 1'b0);
    check_val("t1_empty", {31'd0, EMPTY}, 32'd0);
    check_val("t1_level", {28'd0, LEVEL}, 32'd1);
    read_entry("t1", 8'hA5, 2'b00);
    check_val("t1_empty_after", {31'd0, EMPTY}, 32'd1);

    // 2: 0x3C needs parity 1; send 0 and a bad stop bit
    send_frame(8'h3C, 1'b0, 1'b0, -1, 1'b0);
    read_entry("t2", 8'h3C, 2'b11);

    // 3: nine frames into an 8-deep FIFO
    for (int i = 0; i < 9; i++) begin
      b = 8'h10 + 8'(i);
      send_frame(b, ~^b, 1'b1, -1, 1'b0);
    end
    check_val("t3_full", {31'd0, FULL}, 32'd1);
    check_val("t3_level", {28'd0, LEVEL}, 32'd8);
    check_val("t3_ovf", {31'd0, OVERFLOW}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      read_entry("t3_rd", 8'h10 + 8'(i), 2'b00);
    end
    check_val("t3_empty", {31'd0, EMPTY}, 32'd1);
    CLR_OVERFLOW = 1'b1;
    tick(1);
    CLR_OVERFLOW = 1'b0;
    check_val("t3_ovf_clr", {31'd0, OVERFLOW}, 32'd0);

    // 4: start + 4 data bits, then silence until timeout
    send_bits({6'b111111, 4'b1010, 1'b0}, 5, -1, 1'b0);
    check_val("t4_state_data", {30'd0, STATE}, 32'd1);
    pulses = 0;
    for (int c = 0; c < 51000; c++) begin
      tick(1);
      if (TIMEOUT_PULSE) pulses++;
    end
    check_val("t4_pulses", pulses, 32'd1);
    check_val("t4_state", {30'd0, STATE}, 32'd0);
    check_val("t4_level", {28'd0, LEVEL}, 32'd0);
    send_frame(8'h12, 1'b1, 1'b1, -1, 1'b0);
    read_entry("t4", 8'h12, 2'b00);

    // 5: 2-cycle clock glitch during the high phase of data bit 3
    send_frame(8'h5A, 1'b1, 1'b1, 4, 1'b0);
    check_val("t5_level", {28'd0, LEVEL}, 32'd1);
    read_entry("t5", 8'h5A, 2'b00);

    // 6: fill, then pop in the stop-bit push cycle
    for (int i = 0; i < 8; i++) begin
      b = 8'h80 + 8'(i);
      send_frame(b, ~^b, 1'b1, -1, 1'b0);
    end
    check_val("t6_full", {31'd0, FULL}, 32'd1);
    send_frame(8'hC3, 1'b1, 1'b1, -1, 1'b1);
    check_val("t6_level", {28'd0, LEVEL}, 32'd8);
    check_val("t6_ovf", {31'd0, OVERFLOW}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      read_entry("t6_rd", 8'h80 + 8'(i), 2'b00);
    end
    check_val("t6_last_data", {24'd0, RD_DATA}, 32'h0000_00C3);
    check_val("t6_last_level", {28'd0, LEVEL}, 32'd1);

    // reset mid-frame
    send_bits({7'b1111111, 3'b101, 1'b0}, 4, -1, 1'b0);
    check_val("t6_state_mid", {30'd0, STATE}, 32'd1);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    check_val("t6r_empty", {31'd0, EMPTY}, 32'd1);
    check_val("t6r_full", {31'd0, FULL}, 32'd0);
    check_val("t6r_level", {28'd0, LEVEL}, 32'd0);
    check_val("t6r_ovf", {31'd0, OVERFLOW}, 32'd0);
    check_val("t6r_tmo", {31'd0, TIMEOUT_PULSE}, 32'd0);
    check_val("t6r_state", {30'd0, STATE}, 32'd0);
    check_val("t6r_data", {24'd0, RD_DATA}, 32'd0);
    check_val("t6r_err", {30'd0, RD_ERR}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
